// File: rtl/pwm_decode.sv
// Recovers duty (high time) and period of an asynchronous PWM input in clk cycles,
// flagging inputs that stop producing rising edges as stuck.
module pwm_decode #(
    parameter int PWM_INTERVAL = 1800,
    parameter int TIMEOUT      = 2 * PWM_INTERVAL,
    parameter int OW           = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    output logic [OW-1:0] duty_out,
    output logic [OW-1:0] period_out,
    output logic          valid,
    output logic          stuck
);

    if (TIMEOUT < 2 || PWM_INTERVAL < 1) begin : g_badParam
        $error("pwm_decode: TIMEOUT must be >= 2 and PWM_INTERVAL >= 1");
    end

    localparam logic [OW-1:0] L_TIMEOUT = OW'(TIMEOUT);
    localparam logic [OW-1:0] L_ONE     = OW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    logic          r_s1;
    logic          r_s2;
    logic          r_prev;
    state_t        r_state;
    logic [OW-1:0] r_pc;
    logic [OW-1:0] r_hc;
    logic [OW-1:0] r_duty;
    logic [OW-1:0] r_period;
    logic          r_valid;
    logic          r_stuck;

    logic w_rise;
    logic w_fall;
    logic w_timeout;

    // Two-flop synchronizer plus a history flop so both edges see the same delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= pwm_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign w_rise    = r_s2 & ~r_prev;
    assign w_fall    = ~r_s2 & r_prev;
    assign w_timeout = (r_pc == L_TIMEOUT) && !w_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_hc     <= '0;
            r_duty   <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_stuck  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state <= S_HIGH;
                        r_pc    <= L_ONE;
                        r_hc    <= L_ONE;
                        r_stuck <= 1'b0;
                    end
                end
                // A rise cannot happen while high, so only timeout and fall matter here.
                S_HIGH: begin
                    if (w_timeout) begin
                        r_state  <= S_IDLE;
                        r_duty   <= L_TIMEOUT;
                        r_period <= L_TIMEOUT;
                        r_valid  <= 1'b1;
                        r_stuck  <= 1'b1;
                    end else if (w_fall) begin
                        r_state <= S_LOW;
                        r_pc    <= r_pc + L_ONE;
                    end else begin
                        r_pc <= r_pc + L_ONE;
                        r_hc <= r_hc + L_ONE;
                    end
                end
                S_LOW: begin
                    if (w_rise) begin
                        r_state  <= S_HIGH;
                        r_duty   <= r_hc;
                        r_period <= r_pc;
                        r_valid  <= 1'b1;
                        r_stuck  <= 1'b0;
                        r_pc     <= L_ONE;
                        r_hc     <= L_ONE;
                    end else if (w_timeout) begin
                        r_state  <= S_IDLE;
                        r_duty   <= '0;
                        r_period <= L_TIMEOUT;
                        r_valid  <= 1'b1;
                        r_stuck  <= 1'b1;
                    end else begin
                        r_pc <= r_pc + L_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign duty_out   = r_duty;
    assign period_out = r_period;
    assign valid      = r_valid;
    assign stuck      = r_stuck;

endmodule

// File: tb/tb_pwm_decode.sv
// Self-checking bench for pwm_decode: a sample-level measurement model checked every
// cycle, plus directed scenarios with hand-computed strobe values and timing.
module tb_pwm_decode;

    localparam int PWM_INTERVAL = 100;
    localparam int TIMEOUT      = 200;
    localparam int OW           = $clog2(TIMEOUT + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwm_in = 1'b0;
    logic [OW-1:0] duty_out;
    logic [OW-1:0] period_out;
    logic          valid;
    logic          stuck;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    pwm_decode #(
        .PWM_INTERVAL(PWM_INTERVAL),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .duty_out  (duty_out),
        .period_out(period_out),
        .valid     (valid),
        .stuck     (stuck)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model works on raw input samples: a period runs from one rising sample to the next.
    typedef struct packed {
        logic        active;
        logic        fallen;
        logic        prevS;
        int unsigned elapsed;
        int unsigned highCnt;
        logic        valid;
        int unsigned duty;
        int unsigned period;
        logic        stuck;
    } mstate_t;

    function automatic mstate_t modelStep(input mstate_t s, input logic x);
        mstate_t n = s;
        logic rise = x & ~s.prevS;
        n.valid = 1'b0;
        n.prevS = x;
        if (!s.active) begin
            if (rise) begin
                n.active = 1'b1; n.elapsed = 1; n.highCnt = 1; n.fallen = 1'b0; n.stuck = 1'b0;
            end
        end else if (rise) begin
            n.valid = 1'b1; n.duty = s.highCnt; n.period = s.elapsed; n.stuck = 1'b0;
            n.elapsed = 1; n.highCnt = 1; n.fallen = 1'b0;
        end else if (s.elapsed == TIMEOUT) begin
            n.valid = 1'b1; n.stuck = 1'b1; n.period = TIMEOUT;
            n.duty = s.fallen ? 0 : TIMEOUT;
            n.active = 1'b0;
        end else begin
            n.elapsed = s.elapsed + 1;
            if (!x) n.fallen = 1'b1;
            else if (!s.fallen) n.highCnt = s.highCnt + 1;
        end
        return n;
    endfunction

    mstate_t mState, q1, q2;

    // Two extra stages line the model up with the synchronizer latency of the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mState <= '0;
            q1     <= '0;
            q2     <= '0;
        end else begin
            mState <= modelStep(mState, pwm_in);
            q1     <= mState;
            q2     <= q1;
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (valid !== q2.valid || 32'(duty_out) !== q2.duty ||
            32'(period_out) !== q2.period || stuck !== q2.stuck) begin
            miscompares++;
            $display("[TB] FAIL model cyc=%0d: got v=%b d=%0d p=%0d s=%b, expected v=%b d=%0d p=%0d s=%b",
                     cyc, valid, duty_out, period_out, stuck,
                     q2.valid, q2.duty, q2.period, q2.stuck);
        end
    end

    typedef struct {
        int duty;
        int period;
        int stk;
        int at;
    } event_t;

    event_t events[$];

    always @(negedge clk) begin
        if (rst_n && valid === 1'b1)
            events.push_back('{int'(duty_out), int'(period_out), int'(stuck), cyc});
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkEvent(input string name, input int idx, input int d, input int p, input int s);
        if (idx >= events.size()) begin
            checkOutput({name, " present"}, 0, 1);
        end else begin
            checkOutput({name, " duty"}, events[idx].duty, d);
            checkOutput({name, " period"}, events[idx].period, p);
            checkOutput({name, " stuck"}, events[idx].stk, s);
        end
    endtask

    task automatic applyStimulus(input int high, input int low, input int periods);
        for (int p = 0; p < periods; p++) begin
            pwm_in = 1'b1;
            repeat (high) @(negedge clk);
            pwm_in = 1'b0;
            repeat (low) @(negedge clk);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        events.delete();
        @(negedge clk);
    endtask

    initial begin
        int c0;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkOutput("reset valid", int'(valid), 0);
        checkOutput("reset duty", int'(duty_out), 0);
        checkOutput("reset period", int'(period_out), 0);
        checkOutput("reset stuck", int'(stuck), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Square wave 30/70 and strobe latency.
        events.delete();
        c0 = cyc;
        applyStimulus(30, 70, 5);
        checkOutput("sq count", events.size(), 4);
        for (int i = 0; i < 4; i++) checkEvent("sq", i, 30, 100, 0);
        if (events.size() > 0) checkOutput("sq latency", events[0].at, c0 + 103);
        if (events.size() > 3) checkOutput("sq spacing", events[3].at - events[2].at, 100);

        // Duty extremes.
        doReset();
        applyStimulus(1, 99, 3);
        checkOutput("h1 count", events.size(), 2);
        checkEvent("h1", 0, 1, 100, 0);
        doReset();
        applyStimulus(99, 1, 3);
        checkOutput("h99 count", events.size(), 2);
        checkEvent("h99", 1, 99, 100, 0);

        // Stuck high, then recovery.
        doReset();
        c0 = cyc;
        pwm_in = 1'b1;
        repeat (300) @(negedge clk);
        checkOutput("stuckhi count", events.size(), 1);
        checkEvent("stuckhi", 0, 200, 200, 1);
        if (events.size() > 0) checkOutput("stuckhi time", events[0].at, c0 + 203);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        applyStimulus(30, 70, 1);
        checkOutput("recover stuck", int'(stuck), 0);
        checkOutput("recover no valid", events.size(), 1);
        applyStimulus(30, 70, 2);
        checkOutput("recover count", events.size(), 3);
        checkEvent("recover", 1, 30, 100, 0);

        // Stuck low after a short pulse.
        doReset();
        c0 = cyc;
        applyStimulus(10, 300, 1);
        checkOutput("stucklo count", events.size(), 1);
        checkEvent("stucklo", 0, 0, 200, 1);
        if (events.size() > 0) checkOutput("stucklo time", events[0].at, c0 + 203);

        // Rise coinciding with the timeout boundary.
        doReset();
        applyStimulus(10, 190, 2);
        checkOutput("edge count", events.size(), 1);
        checkEvent("edge", 0, 10, 200, 0);

        // Asynchronous reset mid-high.
        doReset();
        applyStimulus(30, 70, 3);
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("pre-rst duty", int'(duty_out), 30);
        checkOutput("pre-rst period", int'(period_out), 100);
        #2 rst_n = 1'b0;
        pwm_in = 1'b0;
        #1;
        checkOutput("async duty", int'(duty_out), 0);
        checkOutput("async period", int'(period_out), 0);
        checkOutput("async valid", int'(valid), 0);
        checkOutput("async stuck", int'(stuck), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        events.delete();
        @(negedge clk);
        applyStimulus(30, 70, 1);
        checkOutput("postrst first rise", events.size(), 0);
        applyStimulus(30, 70, 1);
        checkOutput("postrst count", events.size(), 1);
        checkEvent("postrst", 0, 30, 100, 0);

        // Fade-style duty ramp.
        doReset();
        for (int d = 6; d <= 96; d += 6) applyStimulus(d, 100 - d, 1);
        applyStimulus(1, 99, 1);
        checkOutput("ramp count", events.size(), 16);
        for (int i = 0; i < 16; i++) checkEvent("ramp", i, 6 * (i + 1), 100, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
